// File: rtl/ysyx_24110015_axi4_sram_slave.sv
// AXI4 SRAM slave: word-organised storage behind a single FSM that serves one
// transaction (write burst or read burst) at a time. Write wins when AW and AR
// arrive together. Optional macro YSYX_24110015_SRAM_ERR_RESP_EN makes beats
// outside the mapped window return DECERR instead of aliasing into storage.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a source keeps valid and its payload stable
// while valid is high and ready is low.
module ysyx_24110015_axi4_sram_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0F00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        werr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [2:0]  eff_size;
    logic [31:0] next_addr;
    logic        cur_ok;
    logic        next_ok;
    logic        ar_ok;
    logic [31:0] rd_ar;
    logic [31:0] rd_next;
    logic        aw_hs;
    logic        ar_hs;
    logic        w_hs;

    // Byte offset from the window base, reduced to a word index; upper bits
    // are dropped so out-of-window addresses alias when errors are disabled.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef YSYX_24110015_SRAM_ERR_RESP_EN
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    assign cur_ok  = in_range(addr_q);
    assign next_ok = in_range(next_addr);
    assign ar_ok   = in_range(araddr);
`else
    assign cur_ok  = 1'b1;
    assign next_ok = 1'b1;
    assign ar_ok   = 1'b1;
`endif

    // Next beat address: FIXED holds, everything else steps by the beat size
    // (sizes wider than the 32-bit bus are clamped to a word).
    always_comb begin
        eff_size  = (size_q > 3'd2) ? 3'd2 : size_q;
        next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << eff_size);
    end

    // Ready signals are decoded from state; arready yields to a concurrent awvalid.
    assign awready = rst && (state == IDLE);
    assign arready = rst && (state == IDLE) && !awvalid;
    assign wready  = rst && (state == WDATA);

    assign aw_hs = awvalid && awready;
    assign ar_hs = arvalid && arready;
    assign w_hs  = wvalid && wready;

    assign rd_ar   = ar_ok   ? mem[word_idx(araddr)]    : 32'd0;
    assign rd_next = next_ok ? mem[word_idx(next_addr)] : 32'd0;

    assign dbg_state = state;

    // Storage write port: enabled byte lanes of the current beat's word; never reset.
    always_ff @(posedge clk) begin
        if (w_hs && cur_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered B and R channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'b00;
            werr_q  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            bid     <= 4'd0;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            rid     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        len_q   <= awlen;
                        size_q  <= awsize;
                        burst_q <= awburst;
                        beat_q  <= 8'd0;
                        werr_q  <= 1'b0;
                        bid     <= awid;
                        state   <= WDATA;
                    end else if (ar_hs) begin
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        size_q  <= arsize;
                        burst_q <= arburst;
                        beat_q  <= 8'd0;
                        rid     <= arid;
                        rvalid  <= 1'b1;
                        rdata   <= rd_ar;
                        rresp   <= ar_ok ? 2'b00 : 2'b11;
                        rlast   <= (arlen == 8'd0);
                        state   <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 8'd1;
                        werr_q <= werr_q | ~cur_ok;
                        // Either an early wlast or the declared length closes the burst.
                        if (wlast || (beat_q == len_q)) begin
                            bvalid <= 1'b1;
                            bresp  <= (werr_q || !cur_ok) ? 2'b11 : 2'b00;
                            state  <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        bresp  <= 2'b00;
                        state  <= IDLE;
                    end
                end
                RDATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            rdata  <= rd_next;
                            rresp  <= next_ok ? 2'b00 : 2'b11;
                            rlast  <= (8'(beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_axi4_sram_slave.sv
// Bench for the AXI4 SRAM slave: directed scenarios plus randomized bursts,
// checked against a word-array model of the storage and AXI beat rules.
module tb_ysyx_24110015_axi4_sram_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0F00_0000;

    logic        clk;
    logic        rst;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic [1:0]  dbg_state;

    int total;
    int bad;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf   [256];
    logic [3:0]  sbuf   [256];
    logic [31:0] rbuf   [256];
    logic        rlbuf  [256];
    logic [3:0]  ridbuf [256];
    logic [1:0]  rrbuf  [256];

    ysyx_24110015_axi4_sram_slave #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: word touched by beat i of a burst, from AXI address rules.
    function automatic int beat_word(input logic [31:0] start, input int i,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        int step;
        step = (size > 3'd2) ? 4 : (1 << size);
        a = (burst == 2'b00) ? start : start + 32'(i * step);
        return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic void model_write(input logic [31:0] start, input logic [2:0] size,
                                        input logic [1:0] burst, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int w;
            w = beat_word(start, i, size, burst);
            for (int b = 0; b < 4; b++) begin
                if (sbuf[i][b]) model_mem[w][8*b +: 8] = wbuf[i][8*b +: 8];
            end
        end
    endfunction

    // Driver tasks
    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
        #1; n = 0;
        while (!awready && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (!awready) begin bad++; $display("FAIL aw_handshake: awready=%b required 1", awready); end
        else @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        #1; n = 0;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (!arready) begin bad++; $display("FAIL ar_handshake: arready=%b required 1", arready); end
        else @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
        #1; n = 0;
        while (!wready && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (!wready) begin bad++; $display("FAIL w_handshake: wready=%b required 1", wready); end
        else @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait(input int delay, output logic [3:0] id_o, output logic [1:0] resp_o);
        int n;
        bready = 1'b0;
        #1; n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (!bvalid) begin bad++; $display("FAIL b_wait: bvalid=%b required 1", bvalid); end
        id_o = bid; resp_o = bresp;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk); #1;
            total++;
            if ({bvalid, bid, bresp} !== {1'b1, id_o, resp_o}) begin
                bad++;
                $display("FAIL b_stable: got {v,id,resp}=%h required %h", {bvalid, bid, bresp}, {1'b1, id_o, resp_o});
            end
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic r_beat(input int delay, output logic [31:0] d_o, output logic l_o,
                          output logic [3:0] id_o, output logic [1:0] resp_o);
        int n;
        rready = 1'b0;
        #1; n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (!rvalid) begin bad++; $display("FAIL r_wait: rvalid=%b required 1", rvalid); end
        d_o = rdata; l_o = rlast; id_o = rid; resp_o = rresp;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk); #1;
            total++;
            if ({rvalid, rdata, rlast, rid, rresp} !== {1'b1, d_o, l_o, id_o, resp_o}) begin
                bad++;
                $display("FAIL r_stable: got {v,d,last,id,resp}=%h required %h",
                         {rvalid, rdata, rlast, rid, rresp}, {1'b1, d_o, l_o, id_o, resp_o});
            end
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                               input int bdelay, output logic [3:0] id_o, output logic [1:0] resp_o);
        aw_send(a, id, len, size, burst);
        for (int i = 0; i < nbeats; i++) w_beat(wbuf[i], sbuf[i], (i == nbeats - 1));
        b_wait(bdelay, id_o, resp_o);
    endtask

    // mode 0: rready at once; 1: one stall per beat (rready toggles); 2: random stalls
    task automatic read_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int mode);
        ar_send(a, id, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            int d;
            d = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            r_beat(d, rbuf[i], rlbuf[i], ridbuf[i], rrbuf[i]);
        end
        #1;
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL r_end: rvalid=%b required 0 after last beat", rvalid); end
    endtask

    // Scenario tasks
    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        total++;
        if ({bresp, rresp, bid, rid} !== 12'h0) begin
            bad++; $display("FAIL reset_ids: got %h required 000", {bresp, rresp, bid, rid});
        end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", rdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({awready, arready, wready} !== 3'b110) begin
            bad++; $display("FAIL reset_release_idle: {aw,ar,w}ready=%b required 110", {awready, arready, wready});
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [3:0] id_o; logic [1:0] resp_o;
        logic [31:0] d; logic l; logic [3:0] ri; logic [1:0] rr;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        write_burst(BASE, 4'd3, 8'd0, 3'd2, 2'b01, 1, 2, id_o, resp_o);
        model_write(BASE, 3'd2, 2'b01, 1);
        total++;
        if ({id_o, resp_o} !== {4'd3, 2'b00}) begin
            bad++; $display("FAIL basic_b: bid/bresp=%h/%h required 3/0", id_o, resp_o);
        end
        ar_send(BASE, 4'd3, 8'd0, 3'd2, 2'b01);
        #1;
        total++;
        if (rvalid !== 1'b1) begin bad++; $display("FAIL basic_latency: rvalid=%b required 1", rvalid); end
        r_beat(0, d, l, ri, rr);
        total++;
        if ({d, l, ri, rr} !== {32'hDEADBEEF, 1'b1, 4'd3, 2'b00}) begin
            bad++; $display("FAIL basic_r: data/last/id/resp=%h/%b/%h/%h required deadbeef/1/3/0", d, l, ri, rr);
        end
        #1;
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL basic_single_beat: rvalid=%b required 0", rvalid); end
    endtask

    task automatic test_len255;
        logic [3:0] id_o; logic [1:0] resp_o;
        int errs;
        for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        write_burst(BASE, 4'd5, 8'd255, 3'd2, 2'b01, 256, 0, id_o, resp_o);
        model_write(BASE, 3'd2, 2'b01, 256);
        total++;
        if ({id_o, resp_o} !== {4'd5, 2'b00}) begin
            bad++; $display("FAIL len255_b: bid/bresp=%h/%h required 5/0", id_o, resp_o);
        end
        read_burst(BASE, 4'd6, 8'd255, 3'd2, 2'b01, 0);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            total++;
            if ({rbuf[i], rlbuf[i], ridbuf[i]} !== {model_mem[i], (i == 255), 4'd6}) begin
                bad++; errs++;
                if (errs < 8) $display("FAIL len255_r beat %0d: data/last/id=%h/%b/%h required %h/%b/6",
                                       i, rbuf[i], rlbuf[i], ridbuf[i], model_mem[i], (i == 255));
            end
        end
    endtask

    task automatic test_incr_stall;
        logic [3:0] id_o; logic [1:0] resp_o;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        write_burst(BASE + 32'h10, 4'd1, 8'd3, 3'd2, 2'b01, 4, 0, id_o, resp_o);
        model_write(BASE + 32'h10, 3'd2, 2'b01, 4);
        read_burst(BASE + 32'h10, 4'd2, 8'd3, 3'd2, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({rbuf[i], rlbuf[i], ridbuf[i]} !== {32'(i + 1), (i == 3), 4'd2}) begin
                bad++; $display("FAIL incr_stall beat %0d: data/last/id=%h/%b/%h required %h/%b/2",
                                i, rbuf[i], rlbuf[i], ridbuf[i], i + 1, (i == 3));
            end
        end
    endtask

    task automatic test_strobe;
        logic [3:0] id_o; logic [1:0] resp_o;
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        write_burst(BASE + 32'h40, 4'd4, 8'd0, 3'd2, 2'b01, 1, 0, id_o, resp_o);
        model_write(BASE + 32'h40, 3'd2, 2'b01, 1);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        write_burst(BASE + 32'h40, 4'd4, 8'd0, 3'd2, 2'b01, 1, 0, id_o, resp_o);
        model_write(BASE + 32'h40, 3'd2, 2'b01, 1);
        read_burst(BASE + 32'h40, 4'd4, 8'd0, 3'd2, 2'b01, 0);
        total++;
        if (rbuf[0] !== 32'h11BB33DD) begin
            bad++; $display("FAIL strobe: data=%h required 11bb33dd", rbuf[0]);
        end
    endtask

    task automatic test_priority;
        logic [3:0] id_o; logic [1:0] resp_o;
        logic [31:0] d; logic l; logic [3:0] ri; logic [1:0] rr;
        logic [31:0] wd;
        wd = $urandom;
        awvalid = 1'b1; awaddr = BASE + 32'h80; awid = 4'd7; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; araddr = BASE + 32'h40; arid = 4'd9; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        #1;
        total++;
        if ({awready, arready} !== 2'b10) begin
            bad++; $display("FAIL priority_idle: {aw,ar}ready=%b required 10", {awready, arready});
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        #1;
        total++;
        if (arready !== 1'b0) begin bad++; $display("FAIL priority_wdata: arready=%b required 0", arready); end
        w_beat(wd, 4'hF, 1'b1);
        wbuf[0] = wd; sbuf[0] = 4'hF;
        model_write(BASE + 32'h80, 3'd2, 2'b01, 1);
        #1;
        total++;
        if ({bvalid, arready} !== 2'b10) begin
            bad++; $display("FAIL priority_wresp: {bvalid,arready}=%b required 10", {bvalid, arready});
        end
        b_wait(1, id_o, resp_o);
        total++;
        if ({id_o, resp_o} !== {4'd7, 2'b00}) begin
            bad++; $display("FAIL priority_b: bid/bresp=%h/%h required 7/0", id_o, resp_o);
        end
        #1;
        total++;
        if (arready !== 1'b1) begin bad++; $display("FAIL priority_ar_after_b: arready=%b required 1", arready); end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        r_beat(0, d, l, ri, rr);
        total++;
        if ({d, l, ri} !== {model_mem[16], 1'b1, 4'd9}) begin
            bad++; $display("FAIL priority_r: data/last/id=%h/%b/%h required %h/1/9", d, l, ri, model_mem[16]);
        end
    endtask

    task automatic test_early_wlast_and_fixed;
        logic [3:0] id_o; logic [1:0] resp_o;
        // INCR len=3 closed by wlast on beat 2: only two words change
        for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        write_burst(BASE + 32'd160, 4'd8, 8'd3, 3'd2, 2'b01, 2, 0, id_o, resp_o);
        model_write(BASE + 32'd160, 3'd2, 2'b01, 2);
        total++;
        if ({id_o, resp_o} !== {4'd8, 2'b00}) begin
            bad++; $display("FAIL early_wlast_b: bid/bresp=%h/%h required 8/0", id_o, resp_o);
        end
        read_burst(BASE + 32'd160, 4'd8, 8'd2, 3'd2, 2'b01, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rbuf[i] !== model_mem[40 + i]) begin
                bad++; $display("FAIL early_wlast_r beat %0d: data=%h required %h", i, rbuf[i], model_mem[40 + i]);
            end
        end
        // FIXED burst: every beat hits the same word, last one wins
        for (int i = 0; i < 3; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        write_burst(BASE + 32'd200, 4'd10, 8'd2, 3'd2, 2'b00, 3, 0, id_o, resp_o);
        model_write(BASE + 32'd200, 3'd2, 2'b00, 3);
        read_burst(BASE + 32'd200, 4'd10, 8'd2, 3'd2, 2'b00, 2);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rbuf[i], rlbuf[i]} !== {wbuf[2], (i == 2)}) begin
                bad++; $display("FAIL fixed_r beat %0d: data/last=%h/%b required %h/%b", i, rbuf[i], rlbuf[i], wbuf[2], (i == 2));
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] id_o; logic [1:0] resp_o;
        for (int t = 0; t < 20; t++) begin
            logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; logic [3:0] id;
            a   = BASE + 32'($urandom_range(0, 200) * 4);
            len = 8'($urandom_range(0, 7));
            sz  = 3'($urandom_range(0, 3));
            bu  = 2'($urandom_range(0, 2));
            id  = 4'($urandom_range(0, 15));
            for (int i = 0; i <= int'(len); i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
            write_burst(a, id, len, sz, bu, int'(len) + 1, int'($urandom_range(0, 2)), id_o, resp_o);
            model_write(a, sz, bu, int'(len) + 1);
            total++;
            if ({id_o, resp_o} !== {id, 2'b00}) begin
                bad++; $display("FAIL random_b t%0d: bid/bresp=%h/%h required %h/0", t, id_o, resp_o, id);
            end
            read_burst(a, ~id, len, sz, bu, 2);
            for (int i = 0; i <= int'(len); i++) begin
                logic [31:0] e;
                e = model_mem[beat_word(a, i, sz, bu)];
                total++;
                if ({rbuf[i], rlbuf[i], ridbuf[i], rrbuf[i]} !== {e, (i == int'(len)), ~id, 2'b00}) begin
                    bad++; $display("FAIL random_r t%0d beat %0d: data/last/id/resp=%h/%b/%h/%h required %h/%b/%h/0",
                                    t, i, rbuf[i], rlbuf[i], ridbuf[i], rrbuf[i], e, (i == int'(len)), ~id);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic l; logic [3:0] ri; logic [1:0] rr;
        ar_send(BASE + 32'h10, 4'd4, 8'd3, 3'd2, 2'b01);
        r_beat(0, d, l, ri, rr);
        #1;
        total++;
        if (rvalid !== 1'b1) begin bad++; $display("FAIL reset_mid_beat2: rvalid=%b required 1", rvalid); end
        rst = 1'b0;
        #1;
        total++;
        if ({rvalid, rlast, arready, awready} !== 4'b0) begin
            bad++; $display("FAIL reset_mid_abort: {rvalid,rlast,arready,awready}=%b required 0000", {rvalid, rlast, arready, awready});
        end
        @(negedge clk);
        rst = 1'b1;
        read_burst(BASE + 32'h14, 4'd11, 8'd0, 3'd2, 2'b01, 0);
        total++;
        if ({rbuf[0], ridbuf[0], rlbuf[0]} !== {model_mem[5], 4'd11, 1'b1}) begin
            bad++; $display("FAIL reset_mid_after: data/id/last=%h/%h/%b required %h/b/1", rbuf[0], ridbuf[0], rlbuf[0], model_mem[5]);
        end
    endtask

    task automatic test_out_of_window;
        read_burst(BASE + 32'(4 * DEPTH), 4'd2, 8'd0, 3'd2, 2'b01, 0);
`ifdef YSYX_24110015_SRAM_ERR_RESP_EN
        total++;
        if ({rrbuf[0], rbuf[0]} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL out_of_window: resp/data=%h/%h required 3/0", rrbuf[0], rbuf[0]);
        end
`else
        total++;
        if ({rrbuf[0], rbuf[0]} !== {2'b00, model_mem[0]}) begin
            bad++; $display("FAIL alias_word0: resp/data=%h/%h required 0/%h", rrbuf[0], rbuf[0], model_mem[0]);
        end
`endif
    endtask

    // Sequencer and final report
    initial begin
        total = 0; bad = 0;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        test_reset;
        test_basic;
        test_len255;
        test_incr_stall;
        test_strobe;
        test_priority;
        test_early_wlast_and_fixed;
        test_random;
        test_reset_mid;
        test_out_of_window;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_axi4_sram_slave.md
YSYX_24110015_AXI4_SRAM_SLAVE -- requirements
Module: ysyx_24110015_axi4_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0F00_0000, meaning the byte address of word 0.
REQ-003 SHALL have one clock and an asynchronous active-low reset; no other clock or reset exists.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- awvalid/awready  in/out  1  write-address handshake.
- awaddr  in  32  write start byte address.
- awid  in  4  write transaction ID.
- awlen  in  8  write beats minus 1.
- awsize  in  3  write beat size.
- awburst  in  2  write burst type.
- wvalid/wready  in/out  1  write-data handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane enables.
- wlast  in  1  final write beat.
- bvalid/bready  out/in  1  write-response handshake.
- bresp  out  2  write response code.
- bid  out  4  write response ID.
- arvalid/arready  in/out  1  read-address handshake.
- araddr  in  32  read start byte address.
- arid  in  4  read transaction ID.
- arlen  in  8  read beats minus 1.
- arsize  in  3  read beat size.
- arburst  in  2  read burst type.
- rvalid/rready  out/in  1  read-data handshake.
- rdata  out  32  read data.
- rresp  out  2  read response code.
- rlast  out  1  final read beat.
- rid  out  4  read data ID.

Function
REQ-005 SHALL implement one FSM with states IDLE, WDATA, WRESP, RDATA; one transaction in service at a time.
REQ-006 In IDLE, awready=arready=1 unless both valids are high: then only awready=1 (write wins), arready=0.
REQ-007 On AW handshake SHALL latch addr/id/len/size/burst and go to WDATA; on AR handshake latch likewise and go to RDATA.
REQ-008 In WDATA wready=1; each W handshake SHALL write enabled byte lanes of the addressed word in the same edge.
REQ-009 Beat address: INCR (2'b01) adds 1<<size per beat; FIXED (2'b00) holds; WRAP (2'b10) treated as INCR; size>2 treated as 2.
REQ-010 Write SHALL leave WDATA on the beat with wlast=1 or beat count == len, whichever first; then WRESP with bvalid=1, bid=latched id.
REQ-011 WRESP SHALL hold bvalid/bid/bresp stable until bready; the handshake returns to IDLE.
REQ-012 RDATA: rvalid asserted the cycle after AR handshake (latency 1); rdata = word at current beat address; rid = latched id; rlast=1 only on beat len.
REQ-013 rvalid/rdata/rlast SHALL stay stable while rready=0; on handshake advance the address and present the next beat next cycle; after the rlast handshake return to IDLE.
REQ-014 awlen/arlen=0 SHALL give exactly one beat; 255 SHALL give 256 beats without counter overflow.
REQ-015 Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.

Reset
REQ-016 While rst=0, FSM SHALL be IDLE; awready, wready, bvalid, arready, rvalid, rlast SHALL be 0; bresp, rresp, bid, rid, rdata SHALL be 0.
REQ-017 Reset mid-burst SHALL abandon the transaction with no response; memory contents SHALL NOT be cleared.
REQ-018 First cycle after reset release SHALL behave as IDLE (REQ-006).

Configuration
REQ-019 With macro YSYX_24110015_SRAM_ERR_RESP_EN defined: beats outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL not write, SHALL return rdata=0, and SHALL give resp 2'b11 (DECERR); bresp=DECERR if any beat erred.
REQ-020 Without the macro: all addresses SHALL alias via REQ-015 truncation; bresp and rresp SHALL always be 2'b00.

Verification
REQ-021 AW addr=BASE, len=0, id=3; W 32'hDEADBEEF, strb=4'hF, wlast=1 -> bvalid, bid=3, bresp=0; AR same addr -> one rvalid beat, rdata=32'hDEADBEEF, rlast=1, rid=3.
REQ-022 INCR write len=3 to BASE+0x10 with data 1..4; read back len=3 with rready toggling 1/0 -> rdata 1,2,3,4 in order, stable during stalls, rlast only on the 4th.
REQ-023 Write strb=4'b0101, data 32'hAABBCCDD over 32'h11223344 -> readback 32'h11BB33DD.
REQ-024 awvalid and arvalid asserted in the same IDLE cycle -> write accepted first; read accepted only after the B handshake.
REQ-025 Reset asserted during the 2nd beat of a len=3 read -> rvalid=0 immediately; new AR after release -> correct data, rid of new request.
REQ-026 With ERR_RESP_EN, read at BASE+4*DEPTH_WORDS -> rresp=2'b11, rdata=0; without the macro -> rresp=0, data of word 0.
